// File: rtl/mc_ctrl_fsm_v2.sv
// Multicycle MIPS-subset control FSM with memory wait states, watchdog FAULT and illegal-opcode flag.
// Optional ADDI decode is built when MC_CTRL_ADDI_EN is defined.
module mc_ctrl_fsm_v2 #(
    parameter int OP_W         = 6,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            memread,
    output logic            memwrite,
    output logic            alusrca,
    output logic            memtoreg,
    output logic            iord,
    output logic            regwrite,
    output logic            regdst,
    output logic            irwrite,
    output logic [1:0]      pcsource,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic            pcen,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            fault,
    output logic [3:0]      state_o
);

    localparam logic [OP_W-1:0] OP_LB    = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(6'b101000);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_CTRL_ADDI_EN
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
`endif

    // A zero-width counter is illegal, so a disabled watchdog still keeps one bit.
    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        S_FAULT   = 4'b0000,
        S_FETCH   = 4'b0001,
        S_BNEEX   = 4'b0010,
        S_DECODE  = 4'b0101,
        S_MEMADR  = 4'b0110,
        S_LBRD    = 4'b0111,
        S_LBWR    = 4'b1000,
        S_SBWR    = 4'b1001,
        S_RTYPEEX = 4'b1010,
        S_RTYPEWR = 4'b1011,
        S_BEQEX   = 4'b1100,
        S_JEX     = 4'b1101
`ifdef MC_CTRL_ADDI_EN
        ,
        S_ADDIEX  = 4'b1110,
        S_ADDIWR  = 4'b1111
`endif
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;

    logic       memread_r, memwrite_r, alusrca_r, memtoreg_r, iord_r;
    logic       regwrite_r, regdst_r, irwrite_r;
    logic [1:0] pcsource_r, alusrcb_r, aluop_r;
    logic       pcwrite, pcwritecond, done_r, illegal_r, fault_r;
    logic       mem_wait, timeout, branch_taken;

    // Handshake: in FETCH/LBRD/SBWR the memory access is held until a cycle with
    // mem_ready=1; that cycle completes the access and the FSM advances on the next edge.
    assign mem_wait = (state == S_FETCH) || (state == S_LBRD) || (state == S_SBWR);
    assign timeout  = (MEM_WAIT_MAX > 0) && mem_wait && !mem_ready && (wait_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_wait && !mem_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state  = state;
        memread_r   = 1'b0;
        memwrite_r  = 1'b0;
        alusrca_r   = 1'b0;
        memtoreg_r  = 1'b0;
        iord_r      = 1'b0;
        regwrite_r  = 1'b0;
        regdst_r    = 1'b0;
        irwrite_r   = 1'b0;
        pcsource_r  = 2'b00;
        alusrcb_r   = 2'b00;
        aluop_r     = 2'b00;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        done_r      = 1'b0;
        illegal_r   = 1'b0;
        fault_r     = 1'b0;
        case (state)
            S_FETCH: begin
                memread_r = 1'b1;
                alusrcb_r = 2'b01;
                irwrite_r = mem_ready;
                pcwrite   = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_r = 2'b11;
                case (op)
                    OP_LB, OP_SB: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_BNE:       next_state = S_BNEEX;
                    OP_J:         next_state = S_JEX;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`endif
                    default: begin
                        next_state = S_FETCH;
                        illegal_r  = 1'b1;
                        done_r     = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_r = 1'b1;
                alusrcb_r = 2'b10;
                if (op == OP_LB)      next_state = S_LBRD;
                else if (op == OP_SB) next_state = S_SBWR;
                else                  next_state = S_FETCH;
            end
            S_LBRD: begin
                memread_r = 1'b1;
                iord_r    = 1'b1;
                if (mem_ready) next_state = S_LBWR;
            end
            S_LBWR: begin
                regwrite_r = 1'b1;
                memtoreg_r = 1'b1;
                done_r     = 1'b1;
                next_state = S_FETCH;
            end
            S_SBWR: begin
                memwrite_r = 1'b1;
                iord_r     = 1'b1;
                if (mem_ready) begin
                    done_r     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca_r  = 1'b1;
                aluop_r    = 2'b10;
                next_state = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regdst_r   = 1'b1;
                regwrite_r = 1'b1;
                done_r     = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca_r   = 1'b1;
                aluop_r     = 2'b01;
                pcsource_r  = 2'b01;
                pcwritecond = 1'b1;
                done_r      = 1'b1;
                next_state  = S_FETCH;
            end
            S_JEX: begin
                pcwrite    = 1'b1;
                pcsource_r = 2'b10;
                done_r     = 1'b1;
                next_state = S_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                alusrca_r  = 1'b1;
                alusrcb_r  = 2'b10;
                next_state = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite_r = 1'b1;
                done_r     = 1'b1;
                next_state = S_FETCH;
            end
`endif
            S_FAULT: begin
                fault_r    = 1'b1;
                next_state = S_FAULT;
            end
            default: next_state = S_FETCH;
        endcase
        if (timeout) next_state = S_FAULT;
    end

    assign branch_taken = (state == S_BNEEX) ? ~zero : zero;

    // Outputs are held low during reset; state_o still shows the register.
    assign memread    = reset_n & memread_r;
    assign memwrite   = reset_n & memwrite_r;
    assign alusrca    = reset_n & alusrca_r;
    assign memtoreg   = reset_n & memtoreg_r;
    assign iord       = reset_n & iord_r;
    assign regwrite   = reset_n & regwrite_r;
    assign regdst     = reset_n & regdst_r;
    assign irwrite    = reset_n & irwrite_r;
    assign pcsource   = reset_n ? pcsource_r : 2'b00;
    assign alusrcb    = reset_n ? alusrcb_r : 2'b00;
    assign aluop      = reset_n ? aluop_r : 2'b00;
    assign pcen       = reset_n & (pcwrite | (pcwritecond & branch_taken));
    assign instr_done = reset_n & done_r;
    assign illegal_op = reset_n & illegal_r;
    assign fault      = reset_n & fault_r;
    assign state_o    = state;

endmodule
